hamming_nibble_packer: RTL and testbench

- Downstream stage of the Hamming(7,4) correction stage.
- Takes corrected 7-bit codewords in the layout D7 D6 D5 P4 D3 P2 P1 (bit 6 down to bit 0) and strips the parity bits to recover 4-bit data nibbles.
- Packs two consecutive nibbles into one byte.
- Buffers bytes in a small FIFO with a valid/ready output handshake, so byte-wide consumers can apply backpressure.

---
 rtl/hamming_nibble_packer_if.sv | 42 ++++
 rtl/hamming_nibble_packer.sv | 112 +++++++++++
 tb/tb_hamming_nibble_packer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_nibble_packer_if.sv
// hamming_nibble_packer_if: handshake and status bundle for hamming_nibble_packer
// Signals:
//   cw_valid/cw_ready/cw_in  codeword input handshake (7-bit corrected codeword)
//   flush                    one-cycle request to emit a pending half byte
//   out_valid/out_ready      byte output handshake
//   byte_out/out_half        packed byte and flushed-partial marker
//   byte_count               bytes pushed into the FIFO since reset
//   residual_err/err_count   only with HAMMING_PACKER_RECHECK_EN defined
// Modports: slave = packer side, master = producer/consumer side.
interface hamming_nibble_packer_if #(
    parameter int CNT_W = 16
);
    logic             cw_valid;
    logic             cw_ready;
    logic [6:0]       cw_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       byte_out;
    logic             out_half;
    logic [CNT_W-1:0] byte_count;
`ifdef HAMMING_PACKER_RECHECK_EN
    logic             residual_err;
    logic [7:0]       err_count;
`endif

    modport slave (
        input  cw_valid, cw_in, flush, out_ready,
        output cw_ready, out_valid, byte_out, out_half, byte_count
`ifdef HAMMING_PACKER_RECHECK_EN
        , output residual_err, err_count
`endif
    );

    modport master (
        output cw_valid, cw_in, flush, out_ready,
        input  cw_ready, out_valid, byte_out, out_half, byte_count
`ifdef HAMMING_PACKER_RECHECK_EN
        , input residual_err, err_count
`endif
    );
endinterface

// File: rtl/hamming_nibble_packer.sv
// hamming_nibble_packer: strips Hamming(7,4) parity, packs nibble pairs into bytes, buffers them in a FIFO
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  hamming_nibble_packer_if.slave (codeword in, flush, byte out, byte_count)
// Parameters: DEPTH FIFO entries (power of two, 2..16), CNT_W byte counter width.
// Optional: define HAMMING_PACKER_RECHECK_EN to add syndrome recheck
//   (bus.residual_err sticky flag, bus.err_count saturating counter).
module hamming_nibble_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    hamming_nibble_packer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {EMPTY, HAVE_HI} state_t;

    state_t           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic             flush_q, flush_d;
    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [OCC_W-1:0] occ_q;
    logic [CNT_W-1:0] bcnt_q;
    logic [3:0]       nib;
    logic             full, accept, pop, push, exec;
    logic [8:0]       push_data;

    assign nib           = {bus.cw_in[6], bus.cw_in[5], bus.cw_in[4], bus.cw_in[2]};
    assign full          = occ_q == OCC_W'(DEPTH);
    assign bus.cw_ready  = !rst && !full;
    assign accept        = bus.cw_valid && bus.cw_ready;
    assign bus.out_valid = occ_q != '0;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.byte_out  = mem_q[rd_q][7:0];
    assign bus.out_half  = mem_q[rd_q][8];
    assign bus.byte_count = bcnt_q;

    // A completing accept always wins over a pending flush, so a flush can
    // never split a byte that is being completed in the same cycle.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        push      = 1'b0;
        push_data = {1'b0, hi_q, nib};
        exec      = state_q == HAVE_HI && flush_q && !full && !accept;
        if (state_q == EMPTY) begin
            if (accept) begin
                hi_d    = nib;
                state_d = HAVE_HI;
            end
        end else if (accept) begin
            push    = 1'b1;
            state_d = EMPTY;
        end else if (exec) begin
            push      = 1'b1;
            push_data = {1'b1, hi_q, 4'b0000};
            state_d   = EMPTY;
        end
        // pending flush survives only while a half byte waits behind a full FIFO
        flush_d = bus.flush || (flush_q && state_q == HAVE_HI && !accept && !exec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            hi_q    <= '0;
            flush_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            bcnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            flush_q <= flush_d;
            if (push) mem_q[wr_q] <= push_data;
            wr_q   <= wr_q + PTR_W'(push);
            rd_q   <= rd_q + PTR_W'(pop);
            occ_q  <= occ_q + OCC_W'(push) - OCC_W'(pop);
            bcnt_q <= bcnt_q + CNT_W'(push);
        end
    end

`ifdef HAMMING_PACKER_RECHECK_EN
    logic [2:0] syn;
    logic       res_q;
    logic [7:0] ecnt_q;

    // syndrome {s4, s2, s1}; any nonzero value means upstream left an error
    assign syn = {bus.cw_in[6] ^ bus.cw_in[5] ^ bus.cw_in[4] ^ bus.cw_in[3],
                  bus.cw_in[6] ^ bus.cw_in[5] ^ bus.cw_in[2] ^ bus.cw_in[1],
                  bus.cw_in[6] ^ bus.cw_in[4] ^ bus.cw_in[2] ^ bus.cw_in[0]};
    assign bus.residual_err = res_q;
    assign bus.err_count    = ecnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= 1'b0;
            ecnt_q <= '0;
        end else if (accept && syn != 3'b000) begin
            res_q  <= 1'b1;
            ecnt_q <= ecnt_q + {7'b0, ecnt_q != 8'hFF};
        end
    end
`endif
endmodule

// File: tb/tb_hamming_nibble_packer.sv
// tb_hamming_nibble_packer: directed and random checks of hamming_nibble_packer against a queue model
module tb_hamming_nibble_packer;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] q[$];
    bit         have = 0;
    logic [3:0] hi = '0;
    bit         pend = 0;
    int         cnt = 0;
    bit         res = 0;
    int         ecnt = 0;
    logic [7:0] held;

    always #5 clk = ~clk;

    hamming_nibble_packer_if #(.CNT_W(CW)) bus();

    hamming_nibble_packer #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit syndrome_nz(input logic [6:0] c);
        return (^(c & 7'b1010101)) || (^(c & 7'b1100110)) || (^(c & 7'b1111000));
    endfunction

    // One clock: drive inputs, compare DUT with model, then advance the model.
    task automatic cycle(input logic r_st, input logic v, input logic [6:0] c,
                         input logic f, input logic r);
        bit         full, acc, newpend;
        logic [3:0] nib;
        @(negedge clk);
        rst = r_st;
        bus.cw_valid = v;
        bus.cw_in = c;
        bus.flush = f;
        bus.out_ready = r;
        #1;
        chk("cw_ready", 32'(bus.cw_ready), 32'(!r_st && q.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("byte_out", 32'(bus.byte_out), 32'(q[0][7:0]));
            chk("out_half", 32'(bus.out_half), 32'(q[0][8]));
        end
        chk("byte_count", 32'(bus.byte_count), 32'(cnt));
`ifdef HAMMING_PACKER_RECHECK_EN
        chk("residual_err", 32'(bus.residual_err), 32'(res));
        chk("err_count", 32'(bus.err_count), 32'(ecnt));
`endif
        nib = {c[6], c[5], c[4], c[2]};
        if (r_st) begin
            q.delete();
            have = 0;
            pend = 0;
            cnt = 0;
            res = 0;
            ecnt = 0;
        end else begin
            full = q.size() == DEPTH;
            acc = v && !full;
            if (r && q.size() > 0) void'(q.pop_front());
            newpend = f;
            if (acc && have) begin
                q.push_back({1'b0, hi, nib});
                have = 0;
                cnt = (cnt + 1) % (1 << CW);
            end else if (acc) begin
                hi = nib;
                have = 1;
            end else if (have && pend && !full) begin
                q.push_back({1'b1, hi, 4'h0});
                have = 0;
                cnt = (cnt + 1) % (1 << CW);
            end else if (have && pend) begin
                newpend = 1;
            end
            pend = newpend;
            if (acc && syndrome_nz(c)) begin
                res = 1;
                if (ecnt < 255) ecnt++;
            end
        end
    endtask

    initial begin
        bus.cw_valid = 0;
        bus.cw_in = '0;
        bus.flush = 0;
        bus.out_ready = 0;
        cycle(1, 0, 7'h00, 0, 0);
        cycle(1, 0, 7'h00, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_byte_out", 32'(bus.byte_out), 32'(0));
        chk("rst_out_half", 32'(bus.out_half), 32'(0));
        chk("rst_byte_count", 32'(bus.byte_count), 32'(0));

        cycle(0, 1, 7'b1010101, 0, 0);
        cycle(0, 1, 7'b0110011, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("pair_valid", 32'(bus.out_valid), 32'(1));
        chk("pair_byte", 32'(bus.byte_out), 32'(8'hB6));
        chk("pair_half", 32'(bus.out_half), 32'(0));
        chk("pair_count", 32'(bus.byte_count), 32'(1));
        cycle(0, 0, 7'h00, 0, 1);

        cycle(0, 1, 7'b1111111, 0, 0);
        cycle(0, 0, 7'h00, 1, 0);
        cycle(0, 0, 7'h00, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("flush_byte", 32'(bus.byte_out), 32'(8'hF0));
        chk("flush_half", 32'(bus.out_half), 32'(1));
        chk("flush_count", 32'(bus.byte_count), 32'(2));
        cycle(0, 0, 7'h00, 0, 1);
        cycle(0, 0, 7'h00, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 7'h00, 0, 0);
        chk("noop_flush", 32'(bus.out_valid), 32'(0));

        cycle(0, 1, 7'b1111111, 0, 0);
        cycle(0, 1, 7'b0010100, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 7'h00, 0, 0);
        chk("flush_acc_byte", 32'(bus.byte_out), 32'(8'hF3));
        chk("flush_acc_half", 32'(bus.out_half), 32'(0));
        cycle(0, 0, 7'h00, 0, 1);
        cycle(0, 0, 7'h00, 0, 0);
        chk("flush_acc_single", 32'(bus.out_valid), 32'(0));

        for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(0, 1, 7'($urandom), 0, 0);
        chk("full_ready", 32'(bus.cw_ready), 32'(0));
        held = q[0][7:0];
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 7'h00, 0, 0);
            chk("stall_hold", 32'(bus.byte_out), 32'(held));
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 7'h00, 0, 1);
        chk("drained", 32'(bus.out_valid), 32'(0));

        for (int i = 0; i < 6; i++) cycle(0, 1, 7'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 7'($urandom), 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 7'($urandom), 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 7'($urandom), 0, 0);
        cycle(1, 0, 7'h00, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_count", 32'(bus.byte_count), 32'(0));
        cycle(0, 1, 7'b1111111, 0, 0);
        cycle(0, 1, 7'b0010100, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("fresh_byte", 32'(bus.byte_out), 32'(8'hF3));
        cycle(0, 0, 7'h00, 0, 1);

        cycle(1, 0, 7'h00, 0, 0);
        for (int i = 0; i < 2 * (1 << CW); i++) cycle(0, 1, 7'($urandom), 0, 1);
        cycle(0, 0, 7'h00, 0, 1);
        chk("count_wrap", 32'(bus.byte_count), 32'(0));

        for (int i = 0; i < 800; i++)
            cycle(0, $urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
        for (int i = 0; i < DEPTH + 4; i++) cycle(0, 0, 7'h00, 0, 1);

`ifdef HAMMING_PACKER_RECHECK_EN
        cycle(1, 0, 7'h00, 0, 0);
        cycle(0, 1, 7'b0000001, 0, 0);
        cycle(0, 1, 7'b0000000, 0, 0);
        cycle(0, 0, 7'h00, 0, 0);
        chk("recheck_res", 32'(bus.residual_err), 32'(1));
        chk("recheck_cnt", 32'(bus.err_count), 32'(1));
        chk("recheck_byte", 32'(bus.byte_out), 32'(8'h00));
        cycle(0, 0, 7'h00, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
